// File: rtl/modmul_pkg.sv
// Shared types and width helpers for the Barrett modular multiplier.
// Latency / backpressure: not applicable (declarations only).
// Holds the FSM state encoding, the default correction limit and width functions.
package modmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    QEST,
    QS,
    SUB,
    CORR,
    DONE
  } modmul_state_t;

  // Largest number of r - s steps allowed after the Barrett estimate.
  localparam int DEFAULT_MAX_CORR = 2;

  // Full a*b product width.
  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  // Width of (ab >> (N-1)) * m, both factors N+1 bits.
  function automatic int qest_w(input int n);
    return 2 * n + 2;
  endfunction

  // Remainder width: wide enough for r < 3s plus the wrap of ab - qs.
  function automatic int r_w(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/modmul_barrett_seq.sv
// Purpose: multi-cycle r = a*b mod s by Barrett reduction, s and m = floor(2^(2N)/s) given per request.
// Latency: out_valid rises 5 + k cycles after the accept edge, k = corrections applied (0..MAX_CORR).
// Backpressure: one request in flight; in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk/reset (async active-low); s_i, m_i, a_i, b_i, tag_i with in_valid/in_ready;
//        r_o, tag_o, err_o with out_valid/out_ready. err_o means the correction limit was hit.
module modmul_barrett_seq
  import modmul_pkg::*;
#(
  parameter int N        = 8,
  parameter int TAG_W    = 4,
  parameter int MAX_CORR = DEFAULT_MAX_CORR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     s_i,
  input  logic [N:0]       m_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     r_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PROD_W = prod_w(N);
  localparam int QEST_W = qest_w(N);
  localparam int R_W    = r_w(N);
  localparam int QS_W   = 2 * N + 1;
  localparam int CNT_W  = $clog2(MAX_CORR + 2);

  modmul_state_t    state;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     s_q;
  logic [N:0]       m_q;
  logic [TAG_W-1:0] tag_q;
  logic [PROD_W-1:0] ab_q;
  logic [N:0]       q_q;
  logic [QS_W-1:0]  qs_q;
  logic [R_W-1:0]   r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [QEST_W-1:0] qest_prod;
  logic [R_W-1:0]    s_ext;
  logic              r_ge_s;

  // ab >> (N-1) leaves N+1 bits, so the product with m fits 2N+2 bits exactly.
  assign qest_prod = QEST_W'(ab_q[PROD_W-1:N-1]) * QEST_W'(m_q);
  assign s_ext     = R_W'(s_q);
  assign r_ge_s    = (r_q >= s_ext);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign r_o       = r_q[N-1:0];
  assign tag_o     = tag_q;
  assign err_o     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      m_q   <= '0;
      tag_q <= '0;
      ab_q  <= '0;
      q_q   <= '0;
      qs_q  <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_i;
            b_q   <= b_i;
            s_q   <= s_i;
            m_q   <= m_i;
            tag_q <= tag_i;
            cnt_q <= '0;
            err_q <= 1'b0;
            state <= MUL;
          end
        end
        MUL: begin
          ab_q  <= PROD_W'(a_q) * PROD_W'(b_q);
          state <= QEST;
        end
        QEST: begin
          q_q   <= qest_prod[QEST_W-1:N+1];
          state <= QS;
        end
        QS: begin
          qs_q  <= QS_W'(q_q) * QS_W'(s_q);
          state <= SUB;
        end
        SUB: begin
          // Only the low N+2 bits matter: the true difference is < 3s < 2^(N+2).
          r_q   <= ab_q[R_W-1:0] - qs_q[R_W-1:0];
          state <= CORR;
        end
        CORR: begin
          if (r_ge_s) begin
            if (cnt_q < CNT_W'(MAX_CORR)) begin
              r_q   <= r_q - s_ext;
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              // Bound exhausted (bad m or operands): report r unreduced.
              err_q <= 1'b1;
              state <= DONE;
            end
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
